// File: rtl/serial_word_deserializer.sv
// Serial-in, parallel-out word receiver with a one-word valid/ready holding stage.
// Words completing while the holding stage is occupied and not draining are dropped and flagged.
module serial_word_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         sin_valid,
  input  logic                         sin_bit,
  input  logic                         msb_first,
  input  logic                         frame_start,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overrun,
  input  logic                         clr_overrun
);

  // state | meaning
  // EMPTY | holding register has no word, out_valid=0
  // FULL  | holding register presents a word, out_valid=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

  localparam int CW = $clog2(WIDTH+1);

  hold_state_t       state_q, state_d;
  logic [WIDTH-1:0]  sr_q;
  logic [WIDTH-1:0]  sr_base;
  logic [WIDTH-1:0]  sr_shift;
  logic [CW-1:0]     cnt_base;
  logic [CW-1:0]     cnt_d;
  logic              dir_q;
  logic              dir_eff;
  logic              word_start;
  logic              complete;
  logic              load;
  logic              set_ovr;

  // frame_start discards the partial word before the current bit is considered
  always_comb begin
    cnt_base   = frame_start ? '0 : bit_count;
    sr_base    = frame_start ? '0 : sr_q;
    word_start = (cnt_base == '0);
    dir_eff    = word_start ? msb_first : dir_q;
    sr_shift   = dir_eff ? {sr_base[WIDTH-2:0], sin_bit}
                         : {sin_bit, sr_base[WIDTH-1:1]};
    complete   = sin_valid && (cnt_base == CW'(WIDTH-1));
    cnt_d      = cnt_base;
    if (sin_valid) begin
      cnt_d = complete ? '0 : cnt_base + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          load    = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (out_ready) load    = 1'b1;
          else           set_ovr = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_q      <= '0;
      bit_count <= '0;
      dir_q     <= 1'b1;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      sr_q      <= sin_valid ? sr_shift : sr_base;
      bit_count <= cnt_d;
      if (sin_valid && word_start) dir_q <= msb_first;
      if (load) out_data <= sr_shift;
      // a new drop in the same cycle as a clear keeps the flag set
      if (set_ovr)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=4): one task per scenario,
// hand-computed expected words, inline comparisons.
module tb_serial_word_deserializer;

  logic       clk;
  logic       resetn;
  logic       sin_valid;
  logic       sin_bit;
  logic       msb_first;
  logic       frame_start;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [2:0] bit_count;
  logic       overrun;
  logic       clr_overrun;

  int checks;
  int failures;

  serial_word_deserializer #(.WIDTH(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sin_valid   (sin_valid),
    .sin_bit     (sin_bit),
    .msb_first   (msb_first),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .bit_count   (bit_count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [3:0] w);
    for (int j = 3; j >= 0; j--) begin
      sin_valid = 1'b1;
      sin_bit   = w[j];
      tick();
    end
    sin_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    sin_valid   = 1'b0;
    sin_bit     = 1'b0;
    msb_first   = 1'b1;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'b0000) begin failures++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
    checks++; if (bit_count !== 3'd0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_msb_first();
    msb_first = 1'b1;
    out_ready = 1'b0;
    sin_valid = 1'b1; sin_bit = 1'b1; tick();
    sin_bit = 1'b0; tick();
    sin_bit = 1'b1; tick();
    checks++; if (bit_count !== 3'd3) begin failures++; $display("FAIL msb_partial_count got=%0d exp=3", bit_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_partial_valid got=%b exp=0", out_valid); end
    sin_bit = 1'b0; tick();
    sin_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 4'b1010) begin failures++; $display("FAIL msb_data got=%b exp=1010", out_data); end
    checks++; if (bit_count !== 3'd0) begin failures++; $display("FAIL msb_count got=%0d exp=0", bit_count); end
    tick();
    checks++; if (out_data !== 4'b1010 || out_valid !== 1'b1) begin failures++; $display("FAIL msb_hold got=%b/%b exp=1/1010", out_valid, out_data); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL msb_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'b1010) begin failures++; $display("FAIL msb_drain_data got=%b exp=1010", out_data); end
  endtask

  task automatic test_lsb_first();
    msb_first = 1'b0;
    sin_valid = 1'b1; sin_bit = 1'b0; tick();
    msb_first = 1'b1;
    sin_bit = 1'b1; tick();
    sin_bit = 1'b0; tick();
    sin_bit = 1'b1; tick();
    sin_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 4'b1010) begin failures++; $display("FAIL lsb_data got=%b exp=1010", out_data); end
    drain();
  endtask

  task automatic test_overrun();
    msb_first = 1'b1;
    out_ready = 1'b0;
    send_bits(4'b1100);
    send_bits(4'b0011);
    checks++; if (out_data !== 4'b1100) begin failures++; $display("FAIL ovr_data got=%b exp=1100", out_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    drain();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    send_bits(4'b1111);
    sin_valid = 1'b1;
    sin_bit = 1'b0; tick();
    tick();
    tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    sin_valid   = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    checks++; if (out_data !== 4'b1111) begin failures++; $display("FAIL ovr_keep_old got=%b exp=1111", out_data); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [3];
    words[0] = 4'b1001;
    words[1] = 4'b0110;
    words[2] = 4'b1111;
    msb_first = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 3; j >= 0; j--) begin
        sin_valid = 1'b1;
        sin_bit   = words[i][j];
        tick();
        if (j == 0) begin
          checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin failures++; $display("FAIL b2b_word%0d got=%b/%b exp=1/%b", i, out_valid, out_data, words[i]); end
        end else begin
          checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap%0d_%0d got=%b exp=0", i, j, out_valid); end
        end
      end
    end
    sin_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_final_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    out_ready = 1'b0;
  endtask

  task automatic test_frame_start();
    msb_first = 1'b1;
    out_ready = 1'b0;
    sin_valid = 1'b1;
    sin_bit = 1'b1; tick();
    tick();
    frame_start = 1'b1; sin_bit = 1'b0; tick();
    frame_start = 1'b0;
    checks++; if (bit_count !== 3'd1) begin failures++; $display("FAIL fs_count got=%0d exp=1", bit_count); end
    sin_valid = 1'b0; tick();
    checks++; if (bit_count !== 3'd1) begin failures++; $display("FAIL fs_gap_count got=%0d exp=1", bit_count); end
    sin_valid = 1'b1;
    sin_bit = 1'b1; tick();
    tick();
    sin_bit = 1'b0; tick();
    sin_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0110) begin failures++; $display("FAIL fs_data got=%b/%b exp=1/0110", out_valid, out_data); end
    drain();
  endtask

  task automatic test_async_reset();
    msb_first = 1'b1;
    out_ready = 1'b0;
    send_bits(4'b1111);
    send_bits(4'b0000);
    sin_valid = 1'b1;
    sin_bit = 1'b1; tick();
    sin_bit = 1'b0; tick();
    sin_valid = 1'b0;
    checks++; if (bit_count !== 3'd2 || overrun !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0d/%b/%b exp=2/1/1", bit_count, overrun, out_valid); end
    #3 resetn = 1'b0;
    #1;
    checks++; if (bit_count !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", bit_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL arst_overrun got=%b exp=0", overrun); end
    checks++; if (out_data !== 4'b0000) begin failures++; $display("FAIL arst_data got=%b exp=0000", out_data); end
    #1 resetn = 1'b1;
    tick();
    send_bits(4'b0001);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0001) begin failures++; $display("FAIL arst_next_word got=%b/%b exp=1/0001", out_valid, out_data); end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_frame_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Serial-in, parallel-out receiver for the bit stream produced by the shift-register datapath: collects WIDTH serial bits, MSB-first or LSB-first, and presents each completed word on a valid/ready output port. A one-word holding register decouples bit reception from the consumer. Words that complete while the holding register is still occupied are dropped and flagged.

## Interface
- WIDTH, 4, bits per word (≥2)
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- sin_valid  input  1  sin_bit is valid this cycle
- sin_bit  input  1  serial data bit
- msb_first  input  1  1: first bit received lands in out_data[WIDTH-1]; 0: first bit received lands in out_data[0]
- frame_start  input  1  synchronous; discards any partial word
- out_valid  output  1  holding register contains a word
- out_data  output  WIDTH  the held word
- out_ready  input  1  consumer accepts the word
- bit_count  output  $clog2(WIDTH+1)  bits collected in the current partial word
- overrun  output  1  sticky flag: a completed word was dropped
- clr_overrun  input  1  synchronous clear for overrun

## Operation
- Reset (async, resetn=0): shift register=0, bit_count=0, out_valid=0, out_data=0, overrun=0, latched direction=1.
- Bit acceptance: on each clk edge with sin_valid=1, the block shifts in sin_bit and increments bit_count.
- Direction is latched when a bit is accepted with bit_count=0. Changes to msb_first mid-word are ignored until the next word starts.
- MSB-first shift: sr <= {sr[WIDTH-2:0], sin_bit}. LSB-first shift: sr <= {sin_bit, sr[WIDTH-1:1]}.
- Completion: the WIDTH-th accepted bit completes the word. The full word (including that bit) is routed to the holding stage, and bit_count returns to 0 on the same edge.
- Holding stage has two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY with completion → FULL; out_data = completed word.
  - FULL with out_ready=1 and no completion → EMPTY. out_data keeps its last value.
  - FULL with out_ready=1 and completion → stays FULL with the new word. This is the back-to-back case and is not an overrun.
  - FULL with out_ready=0 and completion → stays FULL with the old word unchanged. The new word is discarded and overrun is set.
- frame_start=1: partial bits are discarded and bit_count=0.
  - If sin_valid=1 in the same cycle, that bit is accepted as bit 0 of a new word. bit_count becomes 1, and direction is latched from msb_first.
  - frame_start does not affect the holding stage or overrun.
- overrun is sticky. clr_overrun clears it. If set and clear occur in the same cycle, set wins.
- out_ready is ignored while out_valid=0.

## Timing
- Latency: the last bit is accepted at edge N. out_valid=1 and out_data are valid after edge N, observable during cycle N+1.
- Throughput: one bit per cycle sustained. One word per WIDTH cycles with out_ready held high produces no overrun.
- Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1. out_data is stable while out_valid=1 and out_ready=0.
- bit_count, overrun, and out_valid are all registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-word or mid-handshake: everything is cleared immediately, without waiting for a clock edge. The partial word and the held word are lost.
- sin_valid=0 cycles (gaps) hold all state; gaps within a word are allowed.

## Test plan
- Reset, then msb_first=1 with bits 1,0,1,0 on consecutive cycles and out_ready=0 → out_valid=1 one cycle after the 4th bit, out_data=4'b1010, bit_count=0.
- msb_first=0 with bits 0,1,0,1 → out_data=4'b1010. Flipping msb_first to 1 after the first bit has no effect (still 4'b1010).
- out_ready=0 with words 1100 then 0011 sent back to back → out_data stays 1100 and overrun=1 one cycle after the 8th bit. Asserting out_ready then gives out_valid=0. Asserting clr_overrun gives overrun=0. Asserting clr_overrun in the same cycle as a new overrun leaves overrun=1.
- out_ready=1 continuously with 3 back-to-back words (1001, 0110, 1111) → each is presented for one cycle in order and overrun stays 0.
- Bits 1,1 then frame_start with sin_valid=1 and bit 0, then bits 1,1,0 (msb_first=1) → bit_count=1 after the frame_start cycle, out_data=4'b0110.
- Bits 1,0 (bit_count=2) then resetn pulsed low between clock edges → bit_count=0, out_valid=0, overrun=0 immediately. Then bits 0,0,0,1 → out_data=4'b0001.
